// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU among NUM_REQ requesters. At most one
//   pending request is granted per cycle. The granted operation and operands
//   are driven to the ALU, and the ALU result is captured into a one-entry
//   response register tagged with the requester index.
//
// Parameters
//   DATA_WIDTH - operand/result width
//   NUM_REQ    - number of requesters (2..8)
//   ID_WIDTH   - derived, clog2(NUM_REQ), minimum 1
//
// Ports
//   clock, reset                  - clock, asynchronous active-high reset
//   req_valid / req_ready         - per-requester request / grant (one-hot or 0)
//   req_operation/_operand_A/_B   - packed per-requester payload slices
//   alu_operation/_operand_A/_B   - drive to the shared ALU
//   alu_result                    - combinational result from the ALU
//   resp_valid/_id/_result        - registered response
//   resp_ready                    - consumer accepts the response
//
// Configuration macro
//   ALU_ARBITER_FIXED_PRIORITY_EN - when defined, the lowest index always wins
//                                   and no round-robin pointer is kept.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  localparam int ID_WIDTH  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [6*NUM_REQ-1:0]          req_operation,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_A,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_B,
  output logic [5:0]                    alu_operation,
  output logic [DATA_WIDTH-1:0]         alu_operand_A,
  output logic [DATA_WIDTH-1:0]         alu_operand_B,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  output logic                          resp_valid,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [DATA_WIDTH-1:0]         resp_result,
  input  logic                          resp_ready
);

  logic [5:0]            w_op [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_b  [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_op[gi] = req_operation[6*gi +: 6];
      assign w_a[gi]  = req_operand_A[DATA_WIDTH*gi +: DATA_WIDTH];
      assign w_b[gi]  = req_operand_B[DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

  logic                  r_resp_valid;
  logic [ID_WIDTH-1:0]   r_resp_id;
  logic [DATA_WIDTH-1:0] r_resp_result;

  logic                  w_can_issue;
  logic                  w_grant_any;
  logic [ID_WIDTH-1:0]   w_grant_id;
  logic [ID_WIDTH-1:0]   w_ptr;
  logic [ID_WIDTH-1:0]   w_sel;

`ifdef ALU_ARBITER_FIXED_PRIORITY_EN
  assign w_ptr = '0;
`else
  logic [ID_WIDTH-1:0] r_ptr;
  logic [ID_WIDTH-1:0] w_ptr_next;

  assign w_ptr      = r_ptr;
  assign w_ptr_next = (w_grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                             : w_grant_id + ID_WIDTH'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_grant_any) begin
      r_ptr <= w_ptr_next;
    end
  end
`endif

  // A new result may be captured when the register is empty or being drained.
  assign w_can_issue = !r_resp_valid || resp_ready;

  // Scan offsets from farthest to nearest so the entry closest to the pointer
  // is the last (winning) assignment. Wrap is done by subtraction so that
  // non-power-of-two NUM_REQ works.
  always_comb begin
    int idx;
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    idx         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(w_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[ID_WIDTH'(idx)]) begin
        w_grant_any = 1'b1;
        w_grant_id  = ID_WIDTH'(idx);
      end
    end
    // Reset gating keeps req_ready low while reset is held even though the
    // registers already show an empty response slot.
    if (!w_can_issue || reset) begin
      w_grant_any = 1'b0;
    end
  end

  assign req_ready = w_grant_any ? (NUM_REQ'(1) << w_grant_id) : '0;

  // With no grant the ALU sees slice ptr; values are don't-care.
  assign w_sel         = w_grant_any ? w_grant_id : w_ptr;
  assign alu_operation = w_op[w_sel];
  assign alu_operand_A = w_a[w_sel];
  assign alu_operand_B = w_b[w_sel];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_resp_valid  <= 1'b0;
      r_resp_id     <= '0;
      r_resp_result <= '0;
    end else if (w_grant_any) begin
      r_resp_valid  <= 1'b1;
      r_resp_id     <= w_grant_id;
      r_resp_result <= alu_result;
    end else if (resp_ready) begin
      r_resp_valid  <= 1'b0;
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_result = r_resp_result;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU (6-bit operation code, `DATA_WIDTH` operands) among `NUM_REQ` requesters, such as the core pipeline, an enclave-check unit and a debug port. Each cycle it grants at most one pending request, drives the selected operation and operands to the ALU, and captures the result into a one-entry response register tagged with the requester ID. It sits between the requesters and the single ALU instance and owns all ALU inputs.

## Interface
- `DATA_WIDTH`, 32, operand and result width.
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `ID_WIDTH`, derived, equal to clog2(`NUM_REQ`); minimum 1.

- `clock` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input `NUM_REQ`: bit i set means requester i has a request pending.
- `req_ready` output `NUM_REQ`: one-hot or zero; bit i set means requester i is granted this cycle.
- `req_operation` input 6*`NUM_REQ`: ALU operation code; slice i is bits [6i+5:6i].
- `req_operand_A` input `DATA_WIDTH`*`NUM_REQ`: operand A, packed per requester in the same way.
- `req_operand_B` input `DATA_WIDTH`*`NUM_REQ`: operand B, packed per requester in the same way.
- `alu_operation` output 6: operation code driven to the ALU.
- `alu_operand_A` output `DATA_WIDTH`: operand A driven to the ALU.
- `alu_operand_B` output `DATA_WIDTH`: operand B driven to the ALU.
- `alu_result` input `DATA_WIDTH`: combinational result returned by the ALU.
- `resp_valid` output 1: the response register holds a result.
- `resp_id` output `ID_WIDTH`: index of the requester that owns the result.
- `resp_result` output `DATA_WIDTH`: the registered ALU result.
- `resp_ready` input 1: the consumer accepts the response this cycle.

## Operation
- State:
  - round-robin pointer `ptr` (`ID_WIDTH` bits);
  - response register `{resp_valid, resp_id, resp_result}`.
- `can_issue` = !`resp_valid` | `resp_ready`. The response register is either empty or being drained in the same cycle.
- Grant selection:
  - If `can_issue` is 0, no grant is made and `req_ready` is 0.
  - Otherwise the grant goes to the first i with `req_valid[i]` set, searching `ptr`, `ptr`+1, …, wrapping modulo `NUM_REQ`.
- `req_ready` is combinational from `req_valid`, `ptr`, `resp_valid` and `resp_ready`. It never depends on the operation code or the operands.
- ALU drive:
  - On a grant, `alu_*` carry the granted slice.
  - With no grant, `alu_*` carry slice `ptr` and are don't-care. The ALU is combinational, so these values have no side effect.
- On a grant to requester g at a rising edge:
  - `resp_result` is loaded with `alu_result`;
  - `resp_id` is loaded with g;
  - `resp_valid` is set to 1;
  - `ptr` is set to (g+1) mod `NUM_REQ`.
- With no grant and `resp_ready` high, `resp_valid` is cleared to 0. `resp_id` and `resp_result` hold their values.
- With `resp_valid` high and `resp_ready` low, all response state holds; back-pressure stalls every requester.
- Requester contract: `req_valid` and the request payload stay stable until `req_ready` is seen. A request may be withdrawn only if it has not been granted; the arbiter records nothing about unserved requests.
- Operation codes are passed through unchanged. Codes 15..63 produce whatever the ALU returns (0).

## Timing
- Reset values: `resp_valid`=0, `resp_id`=0, `resp_result`=0, `ptr`=0.
- While `reset` is high, `req_ready`=0.
- Asserting `reset` mid-operation discards any buffered response immediately. Requests granted but not yet consumed are lost; requesters must reissue them.
- Latency: a request granted in cycle T has its result on `resp_*` from cycle T+1.
- Throughput: one result per cycle while `resp_ready` stays high.
- Simultaneous drain and grant in the same cycle: the new result replaces the old one with no bubble.
- Wrap-around: a grant to index `NUM_REQ`-1 sets `ptr` to 0.
- Fairness: under continuous requests from every requester, no requester waits more than `NUM_REQ`-1 grants.

## Configuration
- `ALU_ARBITER_FIXED_PRIORITY_EN`
  - Defined: the search always starts at index 0, so the lowest index wins. `ptr` is not implemented and reads as 0.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: hold `reset` with `req_valid`=4'b1111. Required: `req_ready`=0 and `resp_valid`=0. After release, the first grant goes to requester 0.
- Single request: requester 2 sends op 0 with A=5, B=7; `resp_ready`=1. Required: `req_ready`=4'b0100 in T; in T+1, `resp_valid`=1, `resp_id`=2, `resp_result`=12.
- Round-robin: all four requesters continuously valid, each with op 14 and A=10, B=i. Required: grant order 0,1,2,3,0 and results 10,9,8,7,10, one per cycle.
- Back-pressure: `resp_ready`=0 while a response is held. Required: `req_ready`=0 and `resp_*` stable. Raising `resp_ready` produces a grant in the same cycle and the next result in the following cycle.
- Mid-operation reset: assert `reset` while `resp_valid`=1. Required: `resp_valid` goes to 0 asynchronously, before the next clock edge, and `ptr` returns to 0.
- With `ALU_ARBITER_FIXED_PRIORITY_EN` defined: requesters 1 and 3 continuously valid. Required: requester 1 is granted every cycle and requester 3 never.
